// File: rtl/fsm_core.sv
// fsm_core: 8-state Moore controller driving a 4-bit accumulator.
// Each clock it takes a 7-bit command word {go, op[1:0], operand[3:0]}.
// Loaded values can be added, subtracted or XORed with an operand.
// The result is then compared against a target operand.
// The output is simply {state, acc}, straight from the registers.
module fsm_core #(
  parameter int input_len  = 7,
  parameter int output_len = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [input_len-1:0]  in,
  output logic [output_len-1:0] out
);

  // State codes are visible on the output, so the binary encoding is fixed.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_ADD   = 3'd2;
  localparam logic [2:0] ST_SUB   = 3'd3;
  localparam logic [2:0] ST_XOR   = 3'd4;
  localparam logic [2:0] ST_OVF   = 3'd5;
  localparam logic [2:0] ST_CHECK = 3'd6;
  localparam logic [2:0] ST_DONE  = 3'd7;

  // Operation select values seen while in LOAD.
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_IDLE = 2'b11;

  logic [2:0] state_q, state_d;
  logic [3:0] acc_q, acc_d;

  logic       goBit;
  logic [1:0] opSel;
  logic [3:0] operand;
  logic [4:0] sumWide;
  logic [4:0] diffWide;
  logic       carryOut;
  logic       borrowOut;

  assign goBit   = in[6];
  assign opSel   = in[5:4];
  assign operand = in[3:0];

  // The add and subtract are done one bit wider so carry and borrow fall out of the top bit.
  // A borrow appears exactly when acc < operand, because the extended subtraction wraps negative.
  assign sumWide   = {1'b0, acc_q} + {1'b0, operand};
  assign diffWide  = {1'b0, acc_q} - {1'b0, operand};
  assign carryOut  = sumWide[4];
  assign borrowOut = diffWide[4];

  // Next-state and accumulator update; acc holds unless a state explicitly changes it.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    case (state_q)
      ST_IDLE: begin
        if (goBit) begin
          state_d = ST_LOAD;
          acc_d   = operand;
        end
      end
      ST_LOAD: begin
        case (opSel)
          OP_ADD:  state_d = ST_ADD;
          OP_SUB:  state_d = ST_SUB;
          OP_XOR:  state_d = ST_XOR;
          OP_IDLE: state_d = ST_IDLE;
          default: state_d = ST_IDLE;
        endcase
      end
      ST_ADD: begin
        acc_d   = sumWide[3:0];
        state_d = carryOut ? ST_OVF : ST_CHECK;
      end
      ST_SUB: begin
        acc_d   = diffWide[3:0];
        state_d = borrowOut ? ST_OVF : ST_CHECK;
      end
      ST_XOR: begin
        acc_d   = acc_q ^ operand;
        state_d = ST_CHECK;
      end
      ST_OVF: begin
        if (goBit) begin
          state_d = ST_IDLE;
          acc_d   = 4'd0;
        end
      end
      ST_CHECK: begin
        state_d = (acc_q == operand) ? ST_DONE : ST_LOAD;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and accumulator registers; reset wins over every transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
    end
  end

  assign out = {state_q, acc_q};

endmodule

// File: tb/tb_fsm_core.sv
// tb_fsm_core: table vectors, hand sequences and a randomized run against a reference model.
module tb_fsm_core;

  logic       clk;
  logic       rst;
  logic [6:0] in;
  logic [6:0] out;

  int checks;
  int failures;

  typedef struct {
    logic       rst;
    logic [6:0] in;
    logic [6:0] exp;
    string      name;
  } vector_t;

  vector_t vecs[$];

  fsm_core #(.input_len(7), .output_len(7)) dut (
    .clk(clk),
    .rst(rst),
    .in (in),
    .out(out)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive inputs on the falling edge, then sample 1 time unit after the next rising edge.
  task automatic applyStimulus(input logic r, input logic [6:0] x);
    @(negedge clk);
    rst = r;
    in  = x;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%02h expected=0x%02h", name, act, exp);
    end
  endtask

  // Reference model, written straight from the rules of the controller.
  // st is the state number (0..7) and ac is the accumulator (0..15).
  function automatic void modelStep(input logic r, input logic [6:0] x,
                                    inout int st, inout int ac);
    int op;
    int sel;
    op  = int'(x[3:0]);
    sel = int'(x[5:4]);
    if (r) begin
      st = 0;
      ac = 0;
    end else begin
      case (st)
        0: if (x[6]) begin st = 1; ac = op; end
        1: st = (sel == 0) ? 2 : (sel == 1) ? 3 : (sel == 2) ? 4 : 0;
        2: begin st = (ac + op > 15) ? 5 : 6; ac = (ac + op) % 16; end
        3: begin st = (ac < op) ? 5 : 6; ac = (ac - op + 16) % 16; end
        4: begin ac = ac ^ op; st = 6; end
        5: if (x[6]) begin st = 0; ac = 0; end
        6: st = (ac == op) ? 7 : 1;
        default: st = 0;
      endcase
    end
  endfunction

  function automatic vector_t mk(input logic r, input logic [6:0] x,
                                 input logic [6:0] e, input string n);
    vector_t v;
    v.rst  = r;
    v.in   = x;
    v.exp  = e;
    v.name = n;
    return v;
  endfunction

  initial begin
    int st;
    int ac;
    logic [6:0] x;
    logic r;

    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    in       = 7'h00;

    // Reset and idle hold
    vecs.push_back(mk(1'b1, 7'h00, 7'h00, "reset1"));
    vecs.push_back(mk(1'b1, 7'h00, 7'h00, "reset2"));
    vecs.push_back(mk(1'b0, 7'h00, 7'h00, "idle_hold1"));
    vecs.push_back(mk(1'b0, 7'h00, 7'h00, "idle_hold2"));
    // Add and match
    vecs.push_back(mk(1'b0, 7'h45, 7'h15, "add_load"));
    vecs.push_back(mk(1'b0, 7'h00, 7'h25, "add_sel"));
    vecs.push_back(mk(1'b0, 7'h03, 7'h68, "add_check"));
    vecs.push_back(mk(1'b0, 7'h08, 7'h78, "add_done"));
    vecs.push_back(mk(1'b0, 7'h7F, 7'h08, "done_idle"));
    // Add with carry
    vecs.push_back(mk(1'b0, 7'h4C, 7'h1C, "ovf_load"));
    vecs.push_back(mk(1'b0, 7'h00, 7'h2C, "ovf_sel"));
    vecs.push_back(mk(1'b0, 7'h05, 7'h51, "ovf_carry"));
    vecs.push_back(mk(1'b0, 7'h00, 7'h51, "ovf_hold"));
    vecs.push_back(mk(1'b0, 7'h40, 7'h00, "ovf_ack"));
    // Subtract with borrow
    vecs.push_back(mk(1'b0, 7'h43, 7'h13, "sub_load"));
    vecs.push_back(mk(1'b0, 7'h10, 7'h33, "sub_sel"));
    vecs.push_back(mk(1'b0, 7'h05, 7'h5E, "sub_borrow"));
    vecs.push_back(mk(1'b0, 7'h40, 7'h00, "sub_ack"));
    // Subtract without borrow, equal operands give zero
    vecs.push_back(mk(1'b0, 7'h46, 7'h16, "sub0_load"));
    vecs.push_back(mk(1'b0, 7'h10, 7'h36, "sub0_sel"));
    vecs.push_back(mk(1'b0, 7'h06, 7'h60, "sub0_check"));
    vecs.push_back(mk(1'b0, 7'h01, 7'h10, "sub0_miss"));
    vecs.push_back(mk(1'b0, 7'h30, 7'h00, "sub0_idle"));
    // XOR mismatch loop
    vecs.push_back(mk(1'b0, 7'h4A, 7'h1A, "xor_load"));
    vecs.push_back(mk(1'b0, 7'h20, 7'h4A, "xor_sel"));
    vecs.push_back(mk(1'b0, 7'h03, 7'h69, "xor_check"));
    vecs.push_back(mk(1'b0, 7'h00, 7'h19, "xor_miss"));
    vecs.push_back(mk(1'b0, 7'h30, 7'h09, "xor_idle"));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].in);
      checkOutput(vecs[i].name, out, vecs[i].exp);
    end

    // Reset while in ADD beats the pending add
    applyStimulus(1'b0, 7'h45);
    checkOutput("midrst_load", out, 7'h15);
    applyStimulus(1'b0, 7'h00);
    checkOutput("midrst_add", out, 7'h25);
    applyStimulus(1'b1, 7'h0F);
    checkOutput("midrst_reset", out, 7'h00);

    // A reset pulse that falls entirely between edges must be ignored
    applyStimulus(1'b0, 7'h45);
    checkOutput("pulse_load", out, 7'h15);
    @(negedge clk);
    in  = 7'h00;
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    checkOutput("pulse_between", out, 7'h15);
    @(posedge clk);
    #1;
    checkOutput("pulse_after_edge", out, 7'h25);

    // Randomized run against the model
    applyStimulus(1'b1, 7'h00);
    st = 0;
    ac = 0;
    checkOutput("rand_reset", out, 7'h00);
    for (int n = 0; n < 2000; n++) begin
      x = 7'($urandom);
      r = ($urandom_range(0, 31) == 0);
      applyStimulus(r, x);
      modelStep(r, x, st, ac);
      checkOutput("random", out, 7'(st * 16 + ac));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
